// File: rtl/mux_sel_sequencer_if.sv
// mux_sel_sequencer_if: request/dwell inputs and mux select outputs of the select sequencer
interface mux_sel_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               en;
    logic [5:0]         req;
    logic [DWELL_W-1:0] dwell;
    logic               lock;
    logic [2:0]         sel;
    logic               sel_valid;
    logic [5:0]         grant;
    logic               switch_pulse;
    modport master (output en, req, dwell, lock, input sel, sel_valid, grant, switch_pulse);
    modport slave  (input en, req, dwell, lock, output sel, sel_valid, grant, switch_pulse);
endinterface

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: round-robin 6-way mux select generator with minimum dwell and owner lock
module mux_sel_sequencer #(
    parameter int         DWELL_W     = 8,
    parameter logic [2:0] DEFAULT_SEL = 3'd5
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_sel_sequencer_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t             state, nstate;
    logic [2:0]         sel_q, nsel, last, nlast, win;
    logic [DWELL_W-1:0] cnt, ncnt;
    logic               pulse, npulse;
    logic [7:0]         req_x;
    logic [3:0]         s;
    assign req_x = {2'b00, bus.req};
    always_comb begin
        win = last;
        s   = '0;
        for (int i = 6; i >= 1; i--) begin
            s   = {1'b0, last} + 4'(i);
            s   = s >= 4'd6 ? s - 4'd6 : s;
            win = req_x[s[2:0]] ? s[2:0] : win;
        end
    end
    always_comb begin
        nstate = state;
        nsel   = sel_q;
        ncnt   = cnt;
        nlast  = last;
        npulse = 1'b0;
        if (!bus.en) begin
            nstate = IDLE;
            ncnt   = '0;
        end else if (state == IDLE) begin
            if (bus.req != '0) begin
                nstate = HOLD;
                nsel   = win;
                nlast  = win;
                ncnt   = bus.dwell;
                npulse = 1'b1;
            end
        end else if (cnt != '0) begin
            ncnt = cnt - 1'b1;
        end else if (bus.lock && req_x[sel_q]) begin
            ncnt = bus.dwell;
        end else if (bus.req == '0) begin
            nstate = IDLE;
        end else begin
            nsel   = win;
            nlast  = win;
            ncnt   = bus.dwell;
            npulse = win != sel_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= DEFAULT_SEL;
            cnt   <= '0;
            last  <= 3'd5;
            pulse <= 1'b0;
        end else begin
            state <= nstate;
            sel_q <= nsel;
            cnt   <= ncnt;
            last  <= nlast;
            pulse <= npulse;
        end
    end
    assign bus.sel          = sel_q;
    assign bus.sel_valid    = state == HOLD;
    assign bus.grant        = state == HOLD ? 6'd1 << sel_q : 6'd0;
    assign bus.switch_pulse = pulse;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: directed table-driven check of the round-robin select sequencer
module tb_mux_sel_sequencer;
    typedef struct {
        logic       rn;
        logic       en;
        logic [5:0] req;
        logic [7:0] dwell;
        logic       lock;
        logic [2:0] sel;
        logic       v;
        logic [5:0] g;
        logic       p;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vq[$];
    mux_sel_sequencer_if #(.DWELL_W(8)) bus ();
    mux_sel_sequencer #(.DWELL_W(8), .DEFAULT_SEL(3'd5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    function automatic void add(input logic rn, input logic en, input logic [5:0] req, input logic [7:0] dwell,
                                input logic lock, input logic [2:0] sel, input logic v, input logic [5:0] g, input logic p);
        vec_t r;
        r.rn = rn; r.en = en; r.req = req; r.dwell = dwell; r.lock = lock;
        r.sel = sel; r.v = v; r.g = g; r.p = p;
        vq.push_back(r);
    endfunction
    task automatic step(input logic rn, input logic en, input logic [5:0] req, input logic [7:0] dwell, input logic lock);
        rst_n = rn; bus.en = en; bus.req = req; bus.dwell = dwell; bus.lock = lock;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [2:0] es, input logic ev, input logic [5:0] eg, input logic ep);
        n_cmp += 4;
        if (bus.sel !== es) begin n_bad++; $display("FAIL %s sel got %0d want %0d", nm, bus.sel, es); end
        if (bus.sel_valid !== ev) begin n_bad++; $display("FAIL %s sel_valid got %b want %b", nm, bus.sel_valid, ev); end
        if (bus.grant !== eg) begin n_bad++; $display("FAIL %s grant got %b want %b", nm, bus.grant, eg); end
        if (bus.switch_pulse !== ep) begin n_bad++; $display("FAIL %s switch_pulse got %b want %b", nm, bus.switch_pulse, ep); end
        n_cmp++;
        if (bus.sel > 3'd5) begin n_bad++; $display("FAIL %s sel_range got %0d want <=5", nm, bus.sel); end
    endtask
    initial begin
        add(0, 1, 6'b000000, 8'd0, 0, 3'd5, 0, 6'b000000, 0);
        for (int i = 0; i < 10; i++) add(1, 1, 6'b000000, 8'd0, 0, 3'd5, 0, 6'b000000, 0);
        add(1, 1, 6'b000100, 8'd0, 0, 3'd2, 1, 6'b000100, 1);
        add(1, 1, 6'b000100, 8'd0, 0, 3'd2, 1, 6'b000100, 0);
        add(1, 1, 6'b000100, 8'd0, 0, 3'd2, 1, 6'b000100, 0);
        add(1, 0, 6'b000100, 8'd0, 0, 3'd2, 0, 6'b000000, 0);
        add(0, 1, 6'b000000, 8'd1, 0, 3'd5, 0, 6'b000000, 0);
        add(1, 1, 6'b100000, 8'd1, 0, 3'd5, 1, 6'b100000, 1);
        add(1, 1, 6'b100001, 8'd1, 0, 3'd5, 1, 6'b100000, 0);
        add(1, 1, 6'b100001, 8'd1, 0, 3'd0, 1, 6'b000001, 1);
        for (int i = 0; i < 4; i++) add(1, 1, 6'b100001, 8'd1, 1, 3'd0, 1, 6'b000001, 0);
        add(1, 1, 6'b100001, 8'd1, 0, 3'd0, 1, 6'b000001, 0);
        add(1, 1, 6'b100001, 8'd1, 0, 3'd5, 1, 6'b100000, 1);
        add(1, 1, 6'b000001, 8'd1, 1, 3'd5, 1, 6'b100000, 0);
        add(1, 1, 6'b000001, 8'd1, 1, 3'd0, 1, 6'b000001, 1);
        add(0, 1, 6'b000000, 8'd10, 0, 3'd5, 0, 6'b000000, 0);
        add(1, 1, 6'b001000, 8'd10, 0, 3'd3, 1, 6'b001000, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 6'b001000, 8'd10, 0, 3'd3, 1, 6'b001000, 0);
        for (int i = 0; i < 7; i++) add(1, 1, 6'b000000, 8'd10, 0, 3'd3, 1, 6'b001000, 0);
        add(1, 1, 6'b000000, 8'd10, 0, 3'd3, 0, 6'b000000, 0);
        add(1, 1, 6'b000000, 8'd10, 0, 3'd3, 0, 6'b000000, 0);
        add(0, 1, 6'b000000, 8'd20, 0, 3'd5, 0, 6'b000000, 0);
        add(1, 1, 6'b010000, 8'd20, 0, 3'd4, 1, 6'b010000, 1);
        for (int i = 0; i < 4; i++) add(1, 1, 6'b010000, 8'd20, 0, 3'd4, 1, 6'b010000, 0);
        add(0, 0, 6'b010000, 8'd20, 0, 3'd5, 0, 6'b000000, 0);
        add(1, 1, 6'b010010, 8'd20, 0, 3'd1, 1, 6'b000010, 1);
        add(1, 1, 6'b010010, 8'd20, 0, 3'd1, 1, 6'b000010, 0);
        rst_n = 1'b0; bus.en = 1'b0; bus.req = '0; bus.dwell = '0; bus.lock = 1'b0;
        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rn, vq[i].en, vq[i].req, vq[i].dwell, vq[i].lock);
            chk($sformatf("row%0d", i), vq[i].sel, vq[i].v, vq[i].g, vq[i].p);
        end
        step(0, 1, 6'b000000, 8'd2, 0);
        chk("rr_reset", 3'd5, 1'b0, 6'b000000, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            logic [2:0] es;
            es = 3'((k - 1) / 3 % 6);
            step(1, 1, 6'b111111, 8'd2, 0);
            chk($sformatf("rr_edge%0d", k), es, 1'b1, 6'd1 << es, (k - 1) % 3 == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
